// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage, control decoder and ID/EX register:
// PCSrc encodings, exception vectors and the NOP word.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ = 3'b000,
    PCSRC_BR  = 3'b001,
    PCSRC_J   = 3'b010,
    PCSRC_JR  = 3'b011,
    PCSRC_IRQ = 3'b100,
    PCSRC_EXC = 3'b101
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_PC_DEF  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Kernel bit survives the increment; the low 31 bits wrap.
  function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux and IF/ID flush/hold decision for the fetch stage.
module fetch_pc_sel
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = ILLOP_PC_DEF,
  parameter logic [31:0] XADR_PC  = XADR_PC_DEF
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        stall_i,
  input  logic [2:0]  id_pcsrc_i,
  input  logic [31:0] id_jr_target_i,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_branch_target_i,
  input  logic [3:0]  ifid_pc4_hi_i,
  input  logic [25:0] ifid_jidx_i,
  output logic [31:0] next_pc_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic        keep_pc4_o,
  output logic        irq_ack_o
);

  always_comb begin
    next_pc_o  = pc_plus4_i;
    flush_o    = 1'b0;
    hold_o     = 1'b0;
    keep_pc4_o = 1'b0;
    irq_ack_o  = 1'b0;
    if (ex_branch_taken_i) begin
      // EX branch beats a concurrent stall: both IF and ID hold wrong-path work.
      next_pc_o  = ex_branch_target_i;
      flush_o    = 1'b1;
      keep_pc4_o = 1'b1;
    end else if (stall_i) begin
      next_pc_o = pc_i;
      hold_o    = 1'b1;
    end else begin
      case (id_pcsrc_i)
        PCSRC_J: begin
          next_pc_o = {ifid_pc4_hi_i, ifid_jidx_i, 2'b00};
          flush_o   = 1'b1;
        end
        PCSRC_JR: begin
          next_pc_o = id_jr_target_i;
          flush_o   = 1'b1;
        end
        PCSRC_IRQ: begin
          next_pc_o = ILLOP_PC;
          flush_o   = 1'b1;
          irq_ack_o = 1'b1;
        end
        PCSRC_EXC: begin
          next_pc_o = XADR_PC;
          flush_o   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and the
// latched interrupt request presented (masked) to the ID control decoder.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] ILLOP_PC = ILLOP_PC_DEF,
  parameter logic [31:0] XADR_PC  = XADR_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  id_pcsrc,
  input  logic [31:0] id_jr_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        irq_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct,
  output logic        id_irq
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;

  logic [31:0] pc_plus4;
  logic        flush, hold, keep_pc4, irq_ack;

  assign pc_plus4 = pc_inc4(pc_q);

  fetch_pc_sel #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_pc_sel (
    .pc_i               (pc_q),
    .pc_plus4_i         (pc_plus4),
    .stall_i            (stall),
    .id_pcsrc_i         (id_pcsrc),
    .id_jr_target_i     (id_jr_target),
    .ex_branch_taken_i  (ex_branch_taken),
    .ex_branch_target_i (ex_branch_target),
    .ifid_pc4_hi_i      (pc4_q[31:28]),
    .ifid_jidx_i        (instr_q[25:0]),
    .next_pc_o          (pc_d),
    .flush_o            (flush),
    .hold_o             (hold),
    .keep_pc4_o         (keep_pc4),
    .irq_ack_o          (irq_ack)
  );

  always_comb begin
    instr_d = imem_data;
    pc4_d   = pc_plus4;
    valid_d = 1'b1;
    if (hold) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (keep_pc4) pc4_d = pc4_q;
    end
  end

  // A new request in the same cycle as the acknowledge keeps pending set.
  assign irq_d = irq_in | (irq_q & ~irq_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign id_opcode      = instr_q[31:26];
  assign id_funct       = instr_q[5:0];
  // Masked in kernel mode and on bubbles so the saved PC is a real user instruction.
  assign id_irq         = irq_q & valid_q & ~pc4_q[31];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver pushes hand-computed post-edge
// state per cycle, an independent monitor pops and compares after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, ex_branch_taken, irq_in;
  logic [2:0]  id_pcsrc;
  logic [31:0] id_jr_target, ex_branch_target, imem_data;
  logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, id_irq;
  logic [5:0]  id_opcode, id_funct;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .id_pcsrc         (id_pcsrc),
    .id_jr_target     (id_jr_target),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .irq_in           (irq_in),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .id_opcode        (id_opcode),
    .id_funct         (id_funct),
    .id_irq           (id_irq)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        chk_pc4;
    logic        valid;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_n   = 0;

  localparam logic [31:0] I_A = 32'h2001_0005;
  localparam logic [31:0] I_B = 32'h0000_0020;
  localparam logic [31:0] I_C = 32'h8C22_0004;
  localparam logic [31:0] I_J = 32'h0800_0010;
  localparam logic [31:0] I_E = 32'h0000_0025;
  localparam logic [31:0] I_G = 32'h0123_4820;
  localparam logic [31:0] I_H = 32'h0000_0022;
  localparam logic [31:0] I_K = 32'h0000_000C;
  localparam logic [31:0] I_X = 32'hDEAD_BEEF;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry is due after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_addr", e.idx, imem_addr, e.addr);
        chk("if_id_instr", e.idx, if_id_instr, e.instr);
        if (e.chk_pc4) chk("if_id_pc_plus4", e.idx, if_id_pc_plus4, e.pc4);
        chk("if_id_valid", e.idx, {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("id_irq", e.idx, {31'b0, id_irq}, {31'b0, e.irq});
        chk("id_opcode", e.idx, {26'b0, id_opcode}, {26'b0, e.instr[31:26]});
        chk("id_funct", e.idx, {26'b0, id_funct}, {26'b0, e.instr[5:0]});
      end
    end
  end

  task automatic step(
    input logic rst, input logic st, input logic [2:0] src, input logic [31:0] jr,
    input logic ex, input logic [31:0] tgt, input logic irq, input logic [31:0] imem,
    input logic [31:0] e_addr, input logic [31:0] e_instr, input logic [31:0] e_pc4,
    input logic e_cp4, input logic e_v, input logic e_irq);
    exp_t e;
    reset = rst; stall = st; id_pcsrc = src; id_jr_target = jr;
    ex_branch_taken = ex; ex_branch_target = tgt; irq_in = irq; imem_data = imem;
    e.idx = step_n; e.addr = e_addr; e.instr = e_instr; e.pc4 = e_pc4;
    e.chk_pc4 = e_cp4; e.valid = e_v; e.irq = e_irq;
    sb.push_back(e);
    step_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    //    rst st src    jr            ex tgt           irq imem    addr          instr  pc4           cp4 v  irq
    step(1, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_X,   32'h8000_0000, 32'h0, 32'h0,        1, 0, 0);
    // Free run
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_A,   32'h8000_0004, I_A,   32'h8000_0004, 1, 1, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_B,   32'h8000_0008, I_B,   32'h8000_0008, 1, 1, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_C,   32'h8000_000C, I_C,   32'h8000_000C, 1, 1, 0);
    // jr into user space, then fetch the j instruction
    step(0, 0, 3'b011, 32'h0040_0004, 0, 32'h0,       0, I_X,   32'h0040_0004, 32'h0, 32'h8000_0010, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_J,   32'h0040_0008, I_J,   32'h0040_0008, 1, 1, 0);
    // Stall holds everything for two cycles, then the jump resolves
    step(0, 1, 3'b010, 32'h0,        0, 32'h0,        0, I_X,   32'h0040_0008, I_J,   32'h0040_0008, 1, 1, 0);
    step(0, 1, 3'b010, 32'h0,        0, 32'h0,        0, I_X,   32'h0040_0008, I_J,   32'h0040_0008, 1, 1, 0);
    step(0, 0, 3'b010, 32'h0,        0, 32'h0,        0, I_X,   32'h0000_0040, 32'h0, 32'h0040_000C, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_E,   32'h0000_0044, I_E,   32'h0000_0044, 1, 1, 0);
    // EX branch overrides stall and the ID jump
    step(0, 1, 3'b010, 32'h0,        1, 32'h0040_0100, 0, I_X,  32'h0040_0100, 32'h0, 32'h0,        0, 0, 0);
    // IRQ while a user instruction is in IF/ID
    step(0, 0, 3'b011, 32'h0040_000C, 0, 32'h0,       0, I_X,   32'h0040_000C, 32'h0, 32'h0040_0104, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_G,   32'h0040_0010, I_G,   32'h0040_0010, 1, 1, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        1, I_H,   32'h0040_0014, I_H,   32'h0040_0014, 1, 1, 1);
    step(0, 0, 3'b100, 32'h0,        0, 32'h0,        0, I_X,   32'h8000_0004, 32'h0, 32'h0040_0018, 1, 0, 0);
    // IRQ held in kernel mode stays masked until the first user instruction
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        1, I_K,   32'h8000_0008, I_K,   32'h8000_0008, 1, 1, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        1, I_K,   32'h8000_000C, I_K,   32'h8000_000C, 1, 1, 0);
    step(0, 0, 3'b011, 32'h0040_0000, 0, 32'h0,       1, I_X,   32'h0040_0000, 32'h0, 32'h8000_0010, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_G,   32'h0040_0004, I_G,   32'h0040_0004, 1, 1, 1);
    // Set and acknowledge in the same cycle keeps the request pending
    step(0, 0, 3'b100, 32'h0,        0, 32'h0,        1, I_X,   32'h8000_0004, 32'h0, 32'h0040_0008, 1, 0, 0);
    step(0, 0, 3'b011, 32'h0040_0020, 0, 32'h0,       0, I_X,   32'h0040_0020, 32'h0, 32'h8000_0008, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_G,   32'h0040_0024, I_G,   32'h0040_0024, 1, 1, 1);
    // Exception vector, then BR code behaves as sequential
    step(0, 0, 3'b101, 32'h0,        0, 32'h0,        0, I_X,   32'h8000_0008, 32'h0, 32'h0040_0028, 1, 0, 0);
    step(0, 0, 3'b001, 32'h0,        0, 32'h0,        0, I_B,   32'h8000_000C, I_B,   32'h8000_000C, 1, 1, 0);
    // Low-31-bit wrap keeps the kernel bit
    step(0, 0, 3'b011, 32'hFFFF_FFFC, 0, 32'h0,       0, I_X,   32'hFFFF_FFFC, 32'h0, 32'h8000_0010, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_A,   32'h8000_0000, I_A,   32'h8000_0000, 1, 1, 0);
    // Mid-run reset beats stall, branch and irq
    step(1, 1, 3'b010, 32'h0,        1, 32'h0040_0100, 1, I_X,  32'h8000_0000, 32'h0, 32'h0,        1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_C,   32'h8000_0004, I_C,   32'h8000_0004, 1, 1, 0);
    step(0, 0, 3'b011, 32'h0040_0000, 0, 32'h0,       0, I_X,   32'h0040_0000, 32'h0, 32'h8000_0008, 1, 0, 0);
    step(0, 0, 3'b000, 32'h0,        0, 32'h0,        0, I_G,   32'h0040_0004, I_G,   32'h0040_0004, 1, 1, 0);
    step(0, 0, 3'b111, 32'h0,        0, 32'h0,        0, I_B,   32'h0040_0008, I_B,   32'h0040_0008, 1, 1, 0);

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and selects the next PC from the ID-stage PCSrc code and the EX-stage branch resolution.
- Fetches from instruction memory and presents OpCode/Funct/instruction/PC+4 to the ID stage.
- Latches external interrupt requests and presents a masked IRQ to the ID-stage control decoder.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset (kernel mode, bit 31 set).
- ILLOP_PC, 32'h8000_0004, interrupt vector (PCSrc 3'b100).
- XADR_PC, 32'h8000_0008, exception vector (PCSrc 3'b101).

Ports:
- clk  in  1  core clock; one clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit load-use stall: hold PC and IF/ID.
- id_pcsrc  in  3  PCSrc from ID control decoder.
- id_jr_target  in  32  rs value for jr/jalr.
- ex_branch_taken  in  1  conditional branch in EX resolved taken.
- ex_branch_target  in  32  branch target computed in EX.
- irq_in  in  1  external interrupt request (pulse or level).
- imem_addr  out  32  instruction memory address (= PC, combinational).
- imem_data  in  32  instruction word, same cycle.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- id_opcode  out  6  if_id_instr[31:26].
- id_funct  out  6  if_id_instr[5:0].
- id_irq  out  1  masked IRQ to control decoder.

Behaviour:
- Reset: PC=RESET_PC; if_id_instr=0 (nop); if_id_pc_plus4=0; if_id_valid=0; irq_pending=0. Hence id_irq=0 and id_opcode=id_funct=0.
- pc_plus4 = {PC[31], PC[30:0]+31'd4}. Bit 31 is preserved; the low 31 bits wrap modulo 2^31.
- Next-PC priority, highest first:
  1. ex_branch_taken: ex_branch_target. Overrides stall.
  2. stall: hold PC.
  3. id_pcsrc 3'b010: {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
  4. id_pcsrc 3'b011: id_jr_target (all 32 bits, allows kernel exit).
  5. id_pcsrc 3'b100: ILLOP_PC.
  6. id_pcsrc 3'b101: XADR_PC.
  7. id_pcsrc 3'b000, 3'b001, 3'b110 or 3'b111: pc_plus4. 3'b001 is resolved in EX, not here.
- IF/ID update per cycle:
  - ex_branch_taken: flush. instr<=0, valid<=0 (the IF and ID instructions are both wrong-path; ID/EX flush is handled downstream).
  - else stall: hold all IF/ID fields.
  - else id_pcsrc in {010,011,100,101}: flush (instr<=0, valid<=0); pc_plus4<=pc_plus4.
  - else: instr<=imem_data; pc_plus4<=pc_plus4; valid<=1.
- Redirect latency: the target address appears on imem_addr the cycle after the redirect is seen. Exactly one wrong-path slot is squashed for ID redirects, two for EX branches.
- IRQ:
  - irq_pending set on irq_in=1.
  - Cleared when id_pcsrc==3'b100 with stall=0 and ex_branch_taken=0.
  - Set and clear in the same cycle: pending stays 1.
  - id_irq = irq_pending & if_id_valid & ~if_id_pc_plus4[31]. Masked in kernel mode and on bubbles, so the saved PC is always a real instruction.
- Reset asserted mid-operation overrides everything, including stall and redirects, in that cycle.

Decomposition:
- Shared package: PCSrc encodings (PCSRC_SEQ=000, BR=001, J=010, JR=011, IRQ=100, EXC=101), vector constants, NOP word 32'h0.
- Control decoder and ID/EX register import the same package.
- One natural combinational sub-module: fetch_pc_sel (next-PC mux and priority, plus the flush decision). This module keeps the PC, IF/ID and irq_pending registers.

Test Plan:
- Reset, then 3 free-run cycles with imem_data=A,B,C -> imem_addr 80000000, 80000004, 80000008. if_id_instr=A with pc_plus4=80000004, valid=1 after cycle 1.
- IF/ID holds 0x08000010 (j) with pc_plus4=0x00400008; id_pcsrc=010 -> next imem_addr=0x00000040. Next if_id_valid=0, instr=0.
- stall=1 for 2 cycles with id_pcsrc=010 -> PC and IF/ID unchanged both cycles. Jump is taken in the first cycle after stall drops.
- ex_branch_taken=1, target=0x00400100, stall=1 -> imem_addr=0x00400100 next cycle; IF/ID flushed (valid=0).
- irq_in pulse while valid user-mode instr (pc_plus4=0x00400010) -> id_irq=1 next cycle. id_pcsrc=100 -> imem_addr=80000004, pending cleared, id_irq=0 afterwards.
- irq_in held while PC in kernel space (bit31=1) -> id_irq stays 0. After jr to 0x00400000, id_irq=1 once the first user instruction is valid in IF/ID.
